dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder at the far end of the MA-stage load/store interface. The MA stage issues word requests (address, write enable, store data). This block accepts each request, models a configurable access latency, then returns load data or a store acknowledge. While a transaction is outstanding it asserts a busy line, which the pipeline uses to stall MA alongside the existing interlock logic.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
ADDR_W, 10, word-index width, equal to log2(DEPTH)
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-low reset
req_valid  in  1  MA stage presents a request
req_ready  out  1  responder can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address, word aligned
req_wdata  in  32  store data (MDR)
rsp_valid  out  1  response available
rsp_ready  in  1  MA stage consumes the response
rsp_rdata  out  32  load result, 0 for stores and errors
rsp_err  out  1  misaligned or out-of-range access
busy  out  1  transaction in flight, used as a stall to the pipeline

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, req_ready=0 during the reset cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0. Array contents are not cleared.
- busy = (state != IDLE), combinational. req_ready = (state == IDLE) && reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on req_valid && req_ready, capture we, addr, wdata and load cnt = LATENCY-1. Go to WAIT. Requests without req_valid are ignored.
  - WAIT: if cnt != 0, decrement cnt. If cnt == 0, perform the access this edge and go to RESP with rsp_valid=1.
  - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready==1. On the handshake edge go to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
- Latency: a request accepted at edge T gives rsp_valid=1 after edge T+LATENCY. Minimum spacing between accepted requests is LATENCY+2 cycles, because IDLE takes one cycle after the response handshake.
- Access: word index = addr[ADDR_W+1:2].
  - Load: rsp_rdata = mem[index].
  - Store: mem[index] = wdata and rsp_rdata = 0. The write commits only on the WAIT-to-RESP edge.
- Error: if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0, there is no array access and no write. rsp_err=1, rsp_rdata=0, and latency is unchanged.
- A new req_valid while not IDLE is not accepted (req_ready=0). The requester holds the request stable until it is accepted.
- rsp_ready asserted in IDLE or WAIT has no effect.
- Reset mid-transaction: return to IDLE. An uncommitted store is dropped. A store already committed remains in the array.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE=2'd0, WAIT=2'd1, RESP=2'd2}
  - WORD_W=32
  - localparam for the latency counter width (4)
- One natural sub-module, dmem_array: single-port synchronous RAM (DEPTH x 32) with a write enable and registered read. The FSM times its read so the registered data is valid on the WAIT-to-RESP edge.

Test Plan:
1. Reset held low 3 cycles with req_valid=1 -> busy=0, rsp_valid=0, req_ready=0. After release, req_ready=1 next cycle and no transaction is captured.
2. Store addr 0x10, data 0xDEADBEEF, LATENCY=2; then load addr 0x10 -> store: rsp_valid 2 cycles after acceptance with rdata=0, err=0. Load: rdata=0xDEADBEEF.
3. Load addr 0x12 (misaligned) and load addr 0x1000 with DEPTH=1024 -> rsp_err=1, rdata=0. A following load of 0x10 still returns 0xDEADBEEF.
4. rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_rdata and busy stay stable. req_valid pulses during that window are not accepted. After the handshake, the next request is accepted exactly 1 cycle later.
5. Store 0x5 to addr 0x20, reset asserted in WAIT before commit; then load 0x20 -> returns the prior value (0 after a preloaded-zero array), not 0x5.
6. LATENCY=1 and LATENCY=15 builds, load addr 0x0 preloaded with 0xA5A5A5A5 -> rsp_valid at exactly T+1 and T+15, with data 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
`default_nettype none

package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, write-enable plus registered read.
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // A store leaves rdata untouched; the responder masks it to zero anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: MA-stage load/store responder with configurable access latency.
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              txn_we;
  logic              txn_err;
  logic [ADDR_W-1:0] txn_idx;
  logic [WORD_W-1:0] txn_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_en;
  logic              accept;
  logic              addr_err;

  assign req_ready = (state == IDLE) && reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      txn_we    <= 1'b0;
      txn_err   <= 1'b0;
      txn_idx   <= '0;
      txn_wdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        txn_we    <= req_we;
        txn_err   <= addr_err;
        txn_idx   <= req_addr[ADDR_W+1:2];
        txn_wdata <= req_wdata;
      end
    end
  end

  // The array is enabled only on the WAIT-to-RESP edge, so its registered
  // read data lands exactly as RESP begins and stays frozen until the next access.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = RESP;
          mem_en     = !txn_err && reset;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && txn_err;
  assign rsp_rdata = (rsp_valid && !txn_err && !txn_we) ? mem_rdata : '0;

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (txn_we),
    .addr  (txn_idx),
    .wdata (txn_wdata),
    .rdata (mem_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder.
`default_nettype none

module tb_dmem_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        a_valid = 1'b0;
  logic        a_we = 1'b0;
  logic [31:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_rdy = 1'b1;
  logic        a1_req_ready, a1_rsp_valid, a1_rsp_err, a1_busy;
  logic        a15_req_ready, a15_rsp_valid, a15_rsp_err, a15_busy;
  logic [31:0] a1_rdata, a15_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;       // 0 random, 1 low, 2 high
  int last_acc = 0;
  int last_hs = 0;
  logic [32:0] exp_q[$]; // {err, rdata}
  logic [31:0] model [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy));

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a1_req_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a1_rsp_valid), .rsp_ready(a_rdy), .rsp_rdata(a1_rdata),
    .rsp_err(a1_rsp_err), .busy(a1_busy));

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a15_req_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a15_rsp_valid), .rsp_ready(a_rdy), .rsp_rdata(a15_rdata),
    .rsp_err(a15_rsp_err), .busy(a15_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Reference model: word-addressed memory, errors leave it untouched.
  function automatic logic [32:0] expect_rsp(input logic we, input logic [31:0] addr,
                                             input logic [31:0] wdata, input logic upd);
    int idx;
    idx = int'(addr >> 2);
    if (addr % 4 != 0 || addr >= 32'd4096) return {1'b1, 32'h0};
    if (we) begin
      if (upd) model[idx] = wdata;
      return {1'b0, 32'h0};
    end
    return {1'b0, model.exists(idx) ? model[idx] : 32'h0};
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic track);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      last_acc = cyc + 1;
      if (track) exp_q.push_back(expect_rsp(we, addr, wdata, 1'b1));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: latency, stability while stalled, ready/busy relation, scoreboard pop.
  initial begin
    bit prev_valid, prev_hold, acc_pend;
    logic [31:0] prev_rdata;
    logic prev_err;
    logic [32:0] e;
    int acc_edge;
    prev_valid = 0; prev_hold = 0; acc_pend = 0; acc_edge = 0;
    prev_rdata = '0; prev_err = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 0; prev_hold = 0; acc_pend = 0;
      end else begin
        chk("ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
        if (req_valid && req_ready) begin
          acc_edge = cyc + 1;
          acc_pend = 1;
        end
        if (rsp_valid && !prev_valid) begin
          chk("latency", acc_pend ? cyc - acc_edge : 32'hFFFF_FFFF, LATENCY);
          acc_pend = 0;
        end
        if (prev_hold) begin
          chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
          chk("hold_rdata", rsp_rdata, prev_rdata);
          chk("hold_err", {31'd0, rsp_err}, {31'd0, prev_err});
        end
        if (rsp_valid) chk("busy_in_resp", {31'd0, busy}, 32'd1);
        if (rsp_valid && rsp_ready) begin
          last_hs = cyc + 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e[31:0]);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
          end
        end
        prev_valid = rsp_valid;
        prev_hold  = rsp_valid && !rsp_ready;
        prev_rdata = rsp_rdata;
        prev_err   = rsp_err;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 500 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic aux_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int l1, output int l15, output logic [31:0] d1,
                         output logic [31:0] d15);
    int acc;
    bit ok;
    ok = 0; l1 = -1; l15 = -1; d1 = '0; d15 = '0; acc = 0;
    @(posedge clk);
    #1;
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a1_req_ready && a15_req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("aux_accept_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    for (int i = 0; i < 40 && (l1 < 0 || l15 < 0); i++) begin
      @(negedge clk);
      if (a1_rsp_valid && l1 < 0) begin l1 = cyc - acc; d1 = a1_rdata; end
      if (a15_rsp_valid && l15 < 0) begin l15 = cyc - acc; d15 = a15_rdata; end
    end
  endtask

  initial begin
    int l1, l15;
    logic [31:0] d1, d15, addr;
    int k;

    // Reset held with a request pending: nothing accepted, outputs quiet.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Directed store/load and error accesses.
    rdy_mode = 2;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 32'h1000, 32'h0, 1'b1);
    issue(1'b1, 32'h1000, 32'hBAD0_BAD0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    drain();

    // Stalled response: held stable, new requests refused, next accept 1 cycle after handshake.
    rdy_mode = 1;
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid = i[0]; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1111_1111;
      @(negedge clk);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
    end
    rdy_mode = 2;
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    chk("reaccept_gap", last_acc, last_hs + 1);
    drain();

    // Reset before the store commits: store is dropped.
    issue(1'b1, 32'h20, 32'h0, 1'b1);
    drain();
    issue(1'b1, 32'h20, 32'h5, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 1'b1);
    drain();

    // Randomized traffic over a small address pool plus error addresses.
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) issue(1'b1, 32'h40 + 32'(i * 4), $urandom, 1'b1);
    for (int i = 0; i < 80; i++) begin
      addr = 32'h40 + 32'($urandom_range(0, 15) * 4);
      k = $urandom_range(0, 9);
      if (k == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (k == 1) addr = addr | (32'h1 << $urandom_range(12, 31));
      issue(1'($urandom_range(0, 1)), addr, $urandom, 1'b1);
    end
    drain();

    // Latency extremes.
    aux_txn(1'b1, 32'h0, 32'hA5A5_A5A5, l1, l15, d1, d15);
    aux_txn(1'b0, 32'h0, 32'h0, l1, l15, d1, d15);
    chk("lat1_cycles", l1, 32'd1);
    chk("lat15_cycles", l15, 32'd15);
    chk("lat1_rdata", d1, 32'hA5A5_A5A5);
    chk("lat15_rdata", d15, 32'hA5A5_A5A5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
